// File: rtl/func_caller.sv
// Caller-side sequencer: takes (x, y) commands, pulses callee_start, waits for callee_done or timeout,
// returns the result on a valid/ready response stream. Optional golden checker: FUNC_CALLER_CHECK_EN.
module func_caller #(
  parameter int ARG_W   = 8,
  parameter int RET_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ARG_W-1:0] cmd_x,
  input  logic [ARG_W-1:0] cmd_y,
  output logic             callee_start,
  output logic [ARG_W-1:0] callee_a,
  output logic [ARG_W-1:0] callee_b,
  input  logic             callee_done,
  input  logic [RET_W-1:0] callee_ret,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RET_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
`ifdef FUNC_CALLER_CHECK_EN
  ,
  output logic             rsp_mismatch
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             accept_s;
  logic             done_s;
  logic             expire_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cmd_ready_r;
  logic             callee_start_r;
  logic [ARG_W-1:0] callee_a_r;
  logic [ARG_W-1:0] callee_b_r;
  logic             rsp_valid_r;
  logic [RET_W-1:0] rsp_data_r;
  logic             rsp_err_r;
  logic             busy_r;

  // Next-state decode; done is only honoured in WAIT and beats a same-cycle expiry
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    expire_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s     = 1'b1;
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (callee_done) begin
          done_s       = 1'b1;
          next_state_s = ST_RESP;
        end else if (cnt_r == LAST_CNT) begin
          expire_s     = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered control/data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      cmd_ready_r    <= 1'b0;
      callee_start_r <= 1'b0;
      callee_a_r     <= '0;
      callee_b_r     <= '0;
      rsp_valid_r    <= 1'b0;
      rsp_data_r     <= '0;
      rsp_err_r      <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      cmd_ready_r    <= (next_state_s == ST_IDLE);
      callee_start_r <= (next_state_s == ST_START);
      rsp_valid_r    <= (next_state_s == ST_RESP);
      busy_r         <= (next_state_s != ST_IDLE);
      if (accept_s) begin
        callee_a_r <= cmd_x;
        callee_b_r <= cmd_y;
      end
      if (state_r == ST_START) begin
        cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (done_s) begin
        rsp_data_r <= callee_ret;
        rsp_err_r  <= 1'b0;
      end else if (expire_s) begin
        rsp_data_r <= '0;
        rsp_err_r  <= 1'b1;
      end
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign callee_start = callee_start_r;
  assign callee_a     = callee_a_r;
  assign callee_b     = callee_b_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_err      = rsp_err_r;
  assign busy         = busy_r;

`ifdef FUNC_CALLER_CHECK_EN
  localparam int PROD_W = (2 * ARG_W + 2 > RET_W) ? (2 * ARG_W + 2) : RET_W;

  // Reference result (a+b)+(a-b)+(a*b), computed wide and truncated once at the end
  function automatic logic [RET_W-1:0] golden_f(input logic [ARG_W-1:0] a, input logic [ARG_W-1:0] b);
    logic [PROD_W-1:0] ae;
    logic [PROD_W-1:0] be;
    logic [PROD_W-1:0] sum;
    ae  = PROD_W'(a);
    be  = PROD_W'(b);
    sum = (ae + be) + (ae - be) + (ae * be);
    return sum[RET_W-1:0];
  endfunction

  logic [RET_W-1:0] golden_r;
  logic             rsp_mismatch_r;

  // Golden value captured in START, compared against the returned value on done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden_r       <= '0;
      rsp_mismatch_r <= 1'b0;
    end else begin
      if (state_r == ST_START) begin
        golden_r <= golden_f(callee_a_r, callee_b_r);
      end
      if (done_s) begin
        rsp_mismatch_r <= (callee_ret != golden_r);
      end else if (expire_s) begin
        rsp_mismatch_r <= 1'b0;
      end
    end
  end

  assign rsp_mismatch = rsp_mismatch_r;
`endif

endmodule

// File: tb/tb_func_caller.sv
// Self-checking bench for func_caller (TIMEOUT=4): directed calls plus randomized calls against a
// latency/result model derived from the call/timeout rules.
module tb_func_caller;

  localparam int TMO = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic       callee_start;
  logic [7:0] callee_a;
  logic [7:0] callee_b;
  logic       callee_done;
  logic [7:0] callee_ret;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
`ifdef FUNC_CALLER_CHECK_EN
  logic       rsp_mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  func_caller #(.ARG_W(8), .RET_W(8), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .callee_start (callee_start),
    .callee_a     (callee_a),
    .callee_b     (callee_b),
    .callee_done  (callee_done),
    .callee_ret   (callee_ret),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy)
`ifdef FUNC_CALLER_CHECK_EN
    ,
    .rsp_mismatch (rsp_mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One call: callee answers in WAIT cycle 'delay' (late if > TMO), response held off for 'hold' cycles
  task automatic run_call(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ret,
                          input int delay, input int hold, input bit extra_cmd);
    int  exp_lat;
    bit  exp_err;
    logic [7:0] exp_data;
    logic [7:0] golden;
    bit  hs;
    exp_lat  = 2 + ((delay <= TMO) ? delay : TMO);
    exp_err  = (delay > TMO);
    exp_data = exp_err ? 8'd0 : ret;
    golden   = 8'((2 * int'(x)) + (int'(x) * int'(y)));
    hs = 1'b0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y;
    for (int t = 1; t < 60 && !hs; t++) begin
      @(negedge clk);
      cmd_valid = extra_cmd; cmd_x = 8'($urandom); cmd_y = 8'($urandom);
      check("callee_start", callee_start, (t == 1));
      check("callee_a", callee_a, x);
      check("callee_b", callee_b, y);
      check("cmd_ready_busy", cmd_ready, 1'b0);
      check("busy", busy, 1'b1);
      check("rsp_valid", rsp_valid, (t >= exp_lat));
      if (t >= exp_lat) begin
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
`ifdef FUNC_CALLER_CHECK_EN
        check("rsp_mismatch", rsp_mismatch, (!exp_err && (ret != golden)));
`endif
      end
      callee_done = (t == 1 + delay);
      callee_ret  = (t == 1 + delay) ? ret : 8'($urandom);
      rsp_ready   = (t >= exp_lat + hold);
      hs = (t >= exp_lat + hold) && rsp_valid;
    end
    check("handshake_seen", hs, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0; callee_done = 1'b0; rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("cmd_ready_back", cmd_ready, 1'b1);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rx, ry, rr;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_x = 8'd0; cmd_y = 8'd0;
    callee_done = 1'b0; callee_ret = 8'd0; rsp_ready = 1'b0;
    #2;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_start", callee_start, 1'b0);
    check("rst_a", callee_a, 8'd0);
    check("rst_b", callee_b, 8'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    run_call(8'd10, 8'd20, 8'd220, 2, 0, 1'b0);     // basic call
    run_call(8'd200, 8'd3, 8'd232, 1, 0, 1'b0);     // wrap-around, minimum latency
    run_call(8'd200, 8'd3, 8'h10, 3, 0, 1'b0);      // wrong callee result
    run_call(8'd7, 8'd9, 8'h55, 7, 2, 1'b0);        // timeout, late done discarded
    run_call(8'd1, 8'd2, 8'd4, 2, 0, 1'b0);         // normal call after timeout
    run_call(8'd33, 8'd44, 8'hA5, TMO, 0, 1'b0);    // done in the expiry cycle
    run_call(8'd5, 8'd6, 8'h3C, TMO + 1, 0, 1'b0);  // done one cycle too late
    run_call(8'd12, 8'd34, 8'h77, 2, 10, 1'b1);     // backpressure with a pending command

    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      rr = ($urandom_range(0, 1) == 0) ? 8'((2 * int'(rx)) + (int'(rx) * int'(ry))) : 8'($urandom);
      run_call(rx, ry, rr, int'($urandom_range(1, TMO + 2)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT abandons the call
    @(negedge clk);
    cmd_valid = 1'b1; cmd_x = 8'd99; cmd_y = 8'd77;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_a", callee_a, 8'd0);
    check("mid_rst_b", callee_b, 8'd0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_err", rsp_err, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; callee_done = 1'b1; callee_ret = 8'hEE; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 1'b0);
      check("post_rst_ready", cmd_ready, 1'b1);
      check("post_rst_data", rsp_data, 8'd0);
    end
    callee_done = 1'b0; rsp_ready = 1'b0;
    run_call(8'd3, 8'd4, 8'd18, 1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/func_caller.md
Name: func_caller

Overview:
- Caller-side sequencer for FSM-style function blocks that take two arguments and return one result.
- Accepts argument pairs from an upstream valid/ready command stream and drives them to the callee.
- Issues a one-cycle start pulse, then waits for the callee's done strobe, with a timeout.
- Returns the result, or a timeout error, on a downstream valid/ready response stream. Sits between a host/control path and any wrapped function core.

Parameters:
- ARG_W, 8, width of each argument (x, y)
- RET_W, 8, width of callee return value and response data
- TIMEOUT, 255, max cycles spent in WAIT before declaring error (must be >= 1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  upstream command valid
- cmd_ready  output  1  block can accept a command
- cmd_x  input  ARG_W  first argument
- cmd_y  input  ARG_W  second argument
- callee_start  output  1  one-cycle call pulse to callee
- callee_a  output  ARG_W  argument a to callee
- callee_b  output  ARG_W  argument b to callee
- callee_done  input  1  callee result-valid strobe
- callee_ret  input  RET_W  callee return value
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accepts response
- rsp_data  output  RET_W  returned value (0 on error)
- rsp_err  output  1  1 = timeout, no result
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) forces state IDLE and clears every output and internal register.
  - Reset values: cmd_ready=1 once released, callee_start=0, callee_a=callee_b=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, timeout counter=0.
  - Reset mid-call abandons the call; no response is produced.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_x->callee_a and cmd_y->callee_b, then go to START.
- START:
  - callee_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - callee_a/b are stable from the cycle after acceptance until the state returns to IDLE.
- WAIT:
  - Counter increments each cycle.
  - If callee_done=1: latch callee_ret into rsp_data, set rsp_err=0, go to RESP.
  - Else if counter reaches TIMEOUT-1 (i.e. TIMEOUT cycles spent in WAIT): set rsp_data=0, rsp_err=1, go to RESP.
  - If done and expiry occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready go to IDLE, with rsp_valid=0 the next cycle.
- callee_done is ignored in IDLE, START and RESP; a late done after a timeout is discarded.
- cmd_ready=0 in all states except IDLE, so only one call is outstanding.
- Minimum latency:
  - accept at cycle 0, start at cycle 1, done sampled at cycle 2 at the earliest, rsp_valid at cycle 3.
  - Back-to-back throughput is 1 call per 4 cycles with rsp_ready tied high.
- No arithmetic in the datapath; callee_ret passes through unchanged.

Optional Feature:
- Macro: FUNC_CALLER_CHECK_EN
- Defined:
  - Adds output rsp_mismatch (1 bit, reset 0), valid alongside rsp_valid.
  - The block computes a local golden value ((a+b)+(a-b)+(a*b)) mod 2^RET_W, which equals (2a + a*b) mod 2^RET_W, using full-width intermediates with wrap-around truncation at the end.
  - rsp_mismatch=1 when rsp_err=0 and rsp_data != golden; it is forced to 0 on timeout.
  - The golden value is registered during START/WAIT, so it adds no latency.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic call: reset, cmd x=10,y=20; callee model returns 220 after 2 cycles -> callee_start single pulse at cycle 1, callee_a=10, callee_b=20, rsp_data=0xDC, rsp_err=0 (with CHECK_EN: rsp_mismatch=0).
- Wrap-around: x=200,y=3, callee returns 232 -> rsp_data=0xE8; with CHECK_EN, a callee returning 0x10 -> rsp_mismatch=1.
- Timeout, late done ignored: TIMEOUT=4, callee never asserts done -> rsp_valid after 4 WAIT cycles with rsp_err=1, rsp_data=0. A done arriving later is ignored, and the next call completes normally.
- Done vs expiry: done asserted in the exact expiry cycle -> rsp_err=0, rsp_data=callee_ret.
- Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; a second cmd_valid is not accepted until the cycle after the handshake.
- Reset mid-WAIT: rst_n low during WAIT -> all outputs 0 immediately; no rsp_valid after release; cmd_ready=1.
